// File: rtl/instr_mem_loader.sv
// Byte-stream instruction loader: packs big-endian bytes into 32-bit words and
// writes them to consecutive word addresses, holding the core idle meanwhile.
module instr_mem_loader #(
    parameter int DEPTH = 1024,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [31:0]   base_addr,
    input  logic [CW-1:0] word_count,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_data,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          busy,
    output logic          cpu_hold,
    output logic          done,
    output logic [CW-1:0] words_written
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, WRITE} state_t;

    state_t          state;
    logic [AW-1:0]   index;
    logic [CW-1:0]   remaining;
    logic [1:0]      byte_cnt;
    logic [23:0]     word;

    // Address bits above the memory span and the byte offset are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{base_addr[31:AW+2], base_addr[1:0]};

    assign in_ready = (state == RECV);
    assign busy     = (state != IDLE);
    assign cpu_hold = busy;
    assign mem_we   = (state == WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            index         <= '0;
            remaining     <= '0;
            byte_cnt      <= '0;
            word          <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            done          <= 1'b0;
            words_written <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        index         <= base_addr[AW+1:2];
                        remaining     <= word_count;
                        words_written <= '0;
                        byte_cnt      <= '0;
                        if (word_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (in_valid) begin
                        word     <= {word[15:0], in_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        // Address and data are captured here so they are stable
                        // for the whole write cycle and hold afterwards.
                        if (byte_cnt == 2'd3) begin
                            mem_wdata <= {word, in_data};
                            mem_addr  <= {{(30-AW){1'b0}}, index, 2'b00};
                            state     <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    index         <= index + 1'b1;
                    words_written <= words_written + 1'b1;
                    remaining     <= remaining - 1'b1;
                    if (remaining == {{(CW-1){1'b0}}, 1'b1}) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state <= RECV;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader; expected writes come from a simple
// address/byte-packing model of the load.
module tb_instr_mem_loader;
    localparam int DEPTH = 1024;
    localparam int CW    = 11;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [CW-1:0] word_count = '0;
    logic [7:0]    in_data = '0;
    logic          in_ready, mem_we, busy, cpu_hold, done;
    logic [31:0]   mem_addr, mem_wdata;
    logic [CW-1:0] words_written;

    instr_mem_loader #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .cpu_hold(cpu_hold), .done(done),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    int we_cnt, done_cnt, last_we_cyc, last_done_cyc, busy_seen, ready_bad, done_busy_bad;
    bit timeout;
    logic [31:0] cap_addr[$], cap_data[$];
    logic [7:0]  byte_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the memory port and handshake away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_wdata);
            we_cnt++;
            last_we_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (busy) done_busy_bad++;
        end
        if (busy) busy_seen++;
        if (in_ready !== (busy && !mem_we)) ready_bad++;
        if (cpu_hold !== busy) ready_bad++;
    end

    function automatic logic [31:0] model_addr(input logic [31:0] base, input int k);
        return (((base >> 2) + k) % DEPTH) * 4;
    endfunction

    function automatic logic [31:0] model_data(input int k);
        return {byte_q[4*k], byte_q[4*k+1], byte_q[4*k+2], byte_q[4*k+3]};
    endfunction

    task automatic clear_obs();
        cap_addr.delete(); cap_data.delete();
        we_cnt = 0; done_cnt = 0; last_we_cyc = -1; last_done_cyc = -1;
        busy_seen = 0; ready_bad = 0; done_busy_bad = 0; timeout = 0;
    endtask

    task automatic run_load(input logic [31:0] base, input int count, input int gap_max,
                            input bit fixed_gap, input int pulse_at, input int reset_at);
        bit got;
        int w, g;
        clear_obs();
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; word_count = CW'(count);
        @(posedge clk); #1;
        start = 1'b0; base_addr = $urandom; word_count = CW'($urandom);
        for (int i = 0; i < byte_q.size(); i++) begin
            if (i == reset_at) begin
                in_valid = 1'b0;
                #2 rst_n = 1'b0;
                return;
            end
            in_valid = 1'b1; in_data = byte_q[i];
            if (i == pulse_at) begin
                start = 1'b1; base_addr = 32'h100; word_count = CW'(5);
            end
            w = 0;
            do begin
                got = in_ready;
                @(posedge clk); #1;
                start = 1'b0;
                w++;
            end while (!got && w < 50);
            if (!got) begin timeout = 1; break; end
            in_valid = 1'b0; in_data = 8'($urandom);
            g = fixed_gap ? gap_max : $urandom_range(gap_max, 0);
            repeat (g) begin @(posedge clk); #1; end
        end
        w = 0;
        while (done_cnt == 0 && w < 40) begin @(posedge clk); #1; w++; end
        if (done_cnt == 0) timeout = 1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, words_written} !== '0) begin
            errors++; $display("FAIL reset_values got %h want 0",
                {in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, words_written});
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic(input int gap, input string name);
        byte_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        run_load(32'h0, 2, gap, 1'b1, -1, -1);
        checks++; if (timeout) begin errors++; $display("FAIL %s timeout got 1 want 0", name); end
        checks++; if (cap_addr.size() != 2) begin errors++; $display("FAIL %s write_count got %0d want 2", name, cap_addr.size()); end
        else begin
            checks++; if (cap_addr[0] !== 32'h0 || cap_data[0] !== 32'h20080005) begin
                errors++; $display("FAIL %s word0 got %h@%h want 20080005@0", name, cap_data[0], cap_addr[0]); end
            checks++; if (cap_addr[1] !== 32'h4 || cap_data[1] !== 32'h8C090004) begin
                errors++; $display("FAIL %s word1 got %h@%h want 8c090004@4", name, cap_data[1], cap_addr[1]); end
        end
        checks++; if (last_done_cyc != last_we_cyc + 1 || done_cnt != 1) begin
            errors++; $display("FAIL %s done_timing got cyc %0d cnt %0d want cyc %0d cnt 1", name, last_done_cyc, done_cnt, last_we_cyc + 1); end
        checks++; if (words_written !== CW'(2)) begin errors++; $display("FAIL %s words_written got %0d want 2", name, words_written); end
        checks++; if (ready_bad != 0 || done_busy_bad != 0) begin
            errors++; $display("FAIL %s handshake got %0d/%0d bad cycles want 0", name, ready_bad, done_busy_bad); end
    endtask

    task automatic test_zero_count();
        clear_obs();
        @(posedge clk); #1 start = 1'b1; base_addr = 32'h40; word_count = '0;
        @(posedge clk); #1 start = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_done got done %b busy %b want 1 0", done, busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b want 0", done); end
        repeat (3) @(posedge clk); #1;
        checks++; if (we_cnt != 0 || busy_seen != 0 || words_written !== '0) begin
            errors++; $display("FAIL zero_quiet got we %0d busy %0d ww %0d want 0 0 0", we_cnt, busy_seen, words_written); end
    endtask

    task automatic test_wrap();
        byte_q.delete();
        for (int i = 0; i < 12; i++) byte_q.push_back(8'($urandom));
        run_load(32'hFFE, 3, 1, 1'b0, -1, -1);
        checks++; if (timeout || cap_addr.size() != 3) begin
            errors++; $display("FAIL wrap_count got %0d timeout %b want 3 0", cap_addr.size(), timeout); end
        else begin
            checks++; if (cap_addr[0] !== 32'hFFC || cap_addr[1] !== 32'h0 || cap_addr[2] !== 32'h4) begin
                errors++; $display("FAIL wrap_addr got %h %h %h want ffc 0 4", cap_addr[0], cap_addr[1], cap_addr[2]); end
            for (int k = 0; k < 3; k++) begin
                checks++; if (cap_data[k] !== model_data(k)) begin
                    errors++; $display("FAIL wrap_data%0d got %h want %h", k, cap_data[k], model_data(k)); end
            end
        end
    endtask

    task automatic test_start_busy();
        byte_q.delete();
        for (int i = 0; i < 8; i++) byte_q.push_back(8'($urandom));
        run_load(32'h0, 2, 0, 1'b1, 3, -1);
        checks++; if (timeout || cap_addr.size() != 2 || done_cnt != 1) begin
            errors++; $display("FAIL start_busy_count got %0d writes %0d done want 2 1", cap_addr.size(), done_cnt); end
        else begin
            checks++; if (cap_addr[0] !== 32'h0 || cap_addr[1] !== 32'h4 ||
                          cap_data[0] !== model_data(0) || cap_data[1] !== model_data(1)) begin
                errors++; $display("FAIL start_busy_writes got %h@%h %h@%h want %h@0 %h@4", cap_data[0], cap_addr[0],
                    cap_data[1], cap_addr[1], model_data(0), model_data(1)); end
        end
        checks++; if (words_written !== CW'(2)) begin errors++; $display("FAIL start_busy_ww got %0d want 2", words_written); end
    endtask

    task automatic test_reset_mid();
        byte_q.delete();
        for (int i = 0; i < 8; i++) byte_q.push_back(8'($urandom));
        run_load(32'h0, 2, 0, 1'b1, -1, 2);
        #1;
        checks++; if ({in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, words_written} !== '0 || we_cnt != 0) begin
            errors++; $display("FAIL reset_mid_outputs got we_cnt %0d busy %b in_ready %b want 0 0 0", we_cnt, busy, in_ready); end
        @(posedge clk); #1 rst_n = 1'b1;
        test_basic(0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] base;
        int count;
        for (int it = 0; it < 8; it++) begin
            base  = $urandom;
            count = $urandom_range(5, 1);
            byte_q.delete();
            for (int i = 0; i < 4*count; i++) byte_q.push_back(8'($urandom));
            run_load(base, count, 2, 1'b0, -1, -1);
            checks++; if (timeout || cap_addr.size() != count) begin
                errors++; $display("FAIL rand%0d count got %0d want %0d", it, cap_addr.size(), count); end
            else begin
                for (int k = 0; k < count; k++) begin
                    checks++; if (cap_addr[k] !== model_addr(base, k) || cap_data[k] !== model_data(k)) begin
                        errors++; $display("FAIL rand%0d word%0d got %h@%h want %h@%h", it, k, cap_data[k], cap_addr[k],
                            model_data(k), model_addr(base, k)); end
                end
            end
            checks++; if (words_written !== CW'(count) || last_done_cyc != last_we_cyc + 1 || done_busy_bad != 0 || ready_bad != 0) begin
                errors++; $display("FAIL rand%0d completion got ww %0d done_cyc %0d want ww %0d done_cyc %0d",
                    it, words_written, last_done_cyc, count, last_we_cyc + 1); end
        end
    endtask

    initial begin
        #23;
        test_reset();
        test_basic(0, "basic");
        test_basic(3, "backpressure");
        test_zero_count();
        test_wrap();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
